// File: rtl/hh_membrane_update_if.sv
// rtl/hh_membrane_update_if.sv - operand/result handshake bundle for the Hodgkin-Huxley membrane update
//
// Signals:
//   in_valid / in_ready    operand handshake (master -> slave / slave -> master)
//   v, i_ext               membrane potential and injected current, signed Q8.8
//   m, h, n                gating variables, unsigned Q1.15 (0x8000 = 1.0)
//   out_valid / out_ready  result handshake (slave -> master / master -> slave)
//   v_next                 updated potential, signed Q8.8
//   spike                  upward threshold crossing, qualified by out_valid
interface hh_membrane_update_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] v;
    logic signed [15:0] i_ext;
    logic        [15:0] m;
    logic        [15:0] h;
    logic        [15:0] n;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] v_next;
    logic               spike;

    modport master (
        output in_valid, v, i_ext, m, h, n, out_ready,
        input  in_ready, out_valid, v_next, spike
    );

    modport slave (
        input  in_valid, v, i_ext, m, h, n, out_ready,
        output in_ready, out_valid, v_next, spike
    );
endinterface

// File: rtl/hh_membrane_update.sv
// rtl/hh_membrane_update.sv - one forward-Euler step of the Hodgkin-Huxley membrane equation
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    hh_membrane_update_if.slave: operand handshake (v, i_ext, m, h, n),
//          result handshake (v_next, spike)
//
// A single shared multiplier is stepped through a fixed sequence of states,
// one product per state, giving a constant 12-cycle accept-to-valid latency.
module hh_membrane_update #(
    parameter int G_NA     = 30720,
    parameter int G_K      = 9216,
    parameter int G_L      = 77,
    parameter int E_NA     = 12800,
    parameter int E_K      = -19712,
    parameter int E_L      = -13923,
    parameter int DT_SHIFT = 5,
    parameter int V_TH     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hh_membrane_update_if.slave  bus
);

    localparam logic signed [32:0] G_NA33 = 33'(G_NA);
    localparam logic signed [32:0] G_K33  = 33'(G_K);
    localparam logic signed [32:0] G_L33  = 33'(G_L);
    localparam logic signed [16:0] E_NA17 = 17'(E_NA);
    localparam logic signed [16:0] E_K17  = 17'(E_K);
    localparam logic signed [16:0] E_L17  = 17'(E_L);
    localparam logic signed [15:0] V_TH16 = 16'(V_TH);

    typedef enum logic [3:0] {
        S_IDLE, S_M2, S_M3, S_M3H, S_GNA, S_INA, S_N2,
        S_N4, S_GK, S_IK, S_IL, S_SUM, S_DONE
    } state_t;

    state_t             state;
    logic signed [15:0] v_r;
    logic signed [15:0] i_ext_r;
    logic        [15:0] m_r;
    logic        [15:0] h_r;
    logic        [15:0] n_r;
    logic signed [31:0] p;       // m^3 then m^3*h
    logic signed [31:0] q;       // n^2 then n^4
    logic signed [31:0] g;       // scaled conductance for the channel in flight
    logic signed [31:0] i_na;
    logic signed [31:0] i_k;
    logic signed [31:0] i_l;
    logic signed [15:0] v_next_r;
    logic               spike_r;
    logic               out_valid_r;

    // Driving-force terms; 17 bits so v - E never wraps.
    logic signed [16:0] v17;
    logic signed [16:0] diff_na;
    logic signed [16:0] diff_k;
    logic signed [16:0] diff_l;

    assign v17     = {v_r[15], v_r};
    assign diff_na = v17 - E_NA17;
    assign diff_k  = v17 - E_K17;
    assign diff_l  = v17 - E_L17;

    // Shared multiplier: operands chosen by state, result shifted by 15 for
    // Q1.15 gate products and by 8 for conductance * voltage currents.
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic               shift15;
    logic signed [65:0] prod;
    logic signed [65:0] prod_sh;
    logic signed [31:0] mul_res;
    logic               unused_prod_hi;

    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        shift15 = 1'b1;
        case (state)
            S_M2:  begin mul_a = {17'b0, m_r};  mul_b = {17'b0, m_r}; end
            S_M3:  begin mul_a = {p[31], p};    mul_b = {17'b0, m_r}; end
            S_M3H: begin mul_a = {p[31], p};    mul_b = {17'b0, h_r}; end
            S_GNA: begin mul_a = G_NA33;        mul_b = {p[31], p};   end
            S_INA: begin
                mul_a   = {g[31], g};
                mul_b   = {{16{diff_na[16]}}, diff_na};
                shift15 = 1'b0;
            end
            S_N2:  begin mul_a = {17'b0, n_r};  mul_b = {17'b0, n_r}; end
            S_N4:  begin mul_a = {q[31], q};    mul_b = {q[31], q};   end
            S_GK:  begin mul_a = G_K33;         mul_b = {q[31], q};   end
            S_IK:  begin
                mul_a   = {g[31], g};
                mul_b   = {{16{diff_k[16]}}, diff_k};
                shift15 = 1'b0;
            end
            S_IL:  begin
                mul_a   = G_L33;
                mul_b   = {{16{diff_l[16]}}, diff_l};
                shift15 = 1'b0;
            end
            default: ;
        endcase
    end

    assign prod           = mul_a * mul_b;
    assign prod_sh        = shift15 ? (prod >>> 15) : (prod >>> 8);
    assign mul_res        = prod_sh[31:0];
    assign unused_prod_hi = ^prod_sh[65:32];

    // Euler step: dv = (i_ext - i_na - i_k - i_l) * dt, then clamp to 16 bits.
    logic signed [31:0] acc;
    logic signed [31:0] acc_sh;
    logic signed [32:0] sum33;
    logic signed [15:0] v_sat;
    logic               spike_c;

    assign acc    = {{16{i_ext_r[15]}}, i_ext_r} - i_na - i_k - i_l;
    assign acc_sh = acc >>> DT_SHIFT;
    assign sum33  = {{17{v_r[15]}}, v_r} + {acc_sh[31], acc_sh};

    always_comb begin
        if (sum33 > 33'sd32767)
            v_sat = 16'sh7fff;
        else if (sum33 < -33'sd32768)
            v_sat = 16'sh8000;
        else
            v_sat = sum33[15:0];
    end

    assign spike_c = (v_r < V_TH16) && (v_sat >= V_TH16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            v_r         <= '0;
            i_ext_r     <= '0;
            m_r         <= '0;
            h_r         <= '0;
            n_r         <= '0;
            p           <= '0;
            q           <= '0;
            g           <= '0;
            i_na        <= '0;
            i_k         <= '0;
            i_l         <= '0;
            v_next_r    <= '0;
            spike_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        v_r     <= bus.v;
                        i_ext_r <= bus.i_ext;
                        m_r     <= bus.m;
                        h_r     <= bus.h;
                        n_r     <= bus.n;
                        state   <= S_M2;
                    end
                end
                S_M2:  begin p    <= mul_res; state <= S_M3;  end
                S_M3:  begin p    <= mul_res; state <= S_M3H; end
                S_M3H: begin p    <= mul_res; state <= S_GNA; end
                S_GNA: begin g    <= mul_res; state <= S_INA; end
                S_INA: begin i_na <= mul_res; state <= S_N2;  end
                S_N2:  begin q    <= mul_res; state <= S_N4;  end
                S_N4:  begin q    <= mul_res; state <= S_GK;  end
                S_GK:  begin g    <= mul_res; state <= S_IK;  end
                S_IK:  begin i_k  <= mul_res; state <= S_IL;  end
                S_IL:  begin i_l  <= mul_res; state <= S_SUM; end
                S_SUM: begin
                    v_next_r <= v_sat;
                    spike_r  <= spike_c;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle raises out_valid, which lands it on the
                    // 12th edge after acceptance; it then holds until taken.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.v_next    = v_next_r;
    assign bus.spike     = spike_r;

endmodule

// File: tb/tb_hh_membrane_update.sv
// tb/tb_hh_membrane_update.sv - scoreboard bench for hh_membrane_update
module tb_hh_membrane_update;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    hh_membrane_update_if bus();

    hh_membrane_update dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int v;
        int s;
        int acc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after each edge, pops on handshake.
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) begin
        #2;
        if (bus.out_valid && !prev_valid) rise_cyc = cycle;
        prev_valid = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("v_next", int'(bus.v_next), e.v);
                check("spike", int'(bus.spike), e.s);
                check("latency", rise_cyc - e.acc, 12);
            end
        end
    end

    // Called at edge+1; returns at edge+1 just after the accepting edge.
    task automatic send(input int v, input int i_ext, input int m, input int h,
                        input int n, input int ev, input int es, input bit push);
        int wt = 0;
        bus.v        = 16'(v);
        bus.i_ext    = 16'(i_ext);
        bus.m        = 16'(m);
        bus.h        = 16'(h);
        bus.n        = 16'(n);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && wt < 60) begin
            @(posedge clk); #1;
            wt++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (push) sb.push_back('{ev, es, cycle});
        bus.in_valid = 1'b0;
        // Scramble the port values: the captured operands must be unaffected.
        bus.v     = 16'h5a5a;
        bus.i_ext = 16'h7fff;
        bus.m     = 16'hffff;
        bus.h     = 16'hffff;
        bus.n     = 16'hffff;
    endtask

    task automatic drain();
        int wt = 0;
        while ((sb.size() != 0 || !bus.in_ready) && wt < 100) begin
            @(posedge clk); #1;
            wt++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // v, i_ext, m, h, n, expected v_next, expected spike
    int tv_v  [8] = '{-13923, -13923,  -256,  -256, 32767, -32768,     0, -17152};
    int tv_i  [8] = '{     0,   8192, 16384,  8192, 32767, -32768,     0,      0};
    int tv_m  [8] = '{     0,      0,     0,     0,     0,      0, 32768,      0};
    int tv_h  [8] = '{     0,      0,     0,     0,     0,      0, 32768,      0};
    int tv_n  [8] = '{     0,      0,     0,     0,     0,      0, 32768,  49152};
    int tv_ev [8] = '{-13923, -13667,   127,  -129, 32767, -32768, 25693, -31702};
    int tv_es [8] = '{     0,      0,     1,     0,     0,      0,     0,      0};

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.v         = '0;
        bus.i_ext     = '0;
        bus.m         = '0;
        bus.h         = '0;
        bus.n         = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_v_next", int'(bus.v_next), 0);
        check("reset_spike", int'(bus.spike), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", int'(bus.in_ready), 1);

        for (int k = 0; k < 8; k++) begin
            send(tv_v[k], tv_i[k], tv_m[k], tv_h[k], tv_n[k], tv_ev[k], tv_es[k], 1'b1);
            drain();
        end

        // Backpressure with in_valid pulses while busy and while holding.
        begin
            int wt = 0;
            int snap_v;
            int snap_s;
            bus.out_ready = 1'b0;
            send(-256, 16384, 0, 0, 0, 127, 1, 1'b1);
            while (!bus.out_valid && wt < 30) begin
                bus.in_valid = cycle[0];
                bus.v        = 16'(cycle * 97);
                @(posedge clk); #1;
                wt++;
            end
            check("bp_out_valid_seen", int'(bus.out_valid), 1);
            snap_v = int'(bus.v_next);
            snap_s = int'(bus.spike);
            for (int k = 0; k < 5; k++) begin
                bus.in_valid = (k % 2 == 0);
                bus.i_ext    = 16'(k * 1000);
                @(posedge clk); #1;
                check("bp_hold_valid", int'(bus.out_valid), 1);
                check("bp_hold_v_next", int'(bus.v_next), snap_v);
                check("bp_hold_spike", int'(bus.spike), snap_s);
                check("bp_in_ready", int'(bus.in_ready), 0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            drain();
        end

        // Reset during computation: abandoned, then a clean operation.
        send(-256, 16384, 0, 0, 0, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_v_next", int'(bus.v_next), 0);
        check("midrst_spike", int'(bus.spike), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", int'(bus.in_ready), 1);
        repeat (14) @(posedge clk);
        #1;
        check("midrst_no_out_valid", int'(bus.out_valid), 0);
        send(-13923, 8192, 0, 0, 0, -13667, 0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hh_membrane_update.md
HH_MEMBRANE_UPDATE -- requirements
Module: hh_membrane_update

Interface
REQ-001 SHALL have parameter G_NA, default 30720, Na max conductance 120.0 in unsigned Q8.8.
REQ-002 SHALL have parameter G_K, default 9216, K max conductance 36.0 in unsigned Q8.8.
REQ-003 SHALL have parameter G_L, default 77, leak conductance 0.3 in unsigned Q8.8.
REQ-004 SHALL have parameters E_NA / E_K / E_L, defaults 12800 / -19712 / -13923, reversal potentials 50 / -77 / -54.387 mV in signed Q8.8.
REQ-005 SHALL have parameter DT_SHIFT, default 5, with dt = 2^-DT_SHIFT ms and C = 1 uF/cm2.
REQ-006 SHALL have parameter V_TH, default 0, spike threshold in signed Q8.8.
REQ-007 SHALL have ports:
- clk  in  1  clock, rising edge;
- rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports:
- in_valid  in  1  operand set valid;
- in_ready  out  1  block can accept operands.
REQ-009 SHALL have ports:
- v  in  16  membrane potential, signed Q8.8 mV;
- i_ext  in  16  injected current, signed Q8.8.
REQ-010 SHALL have port m, h, n  in  16 each  gating variables, unsigned Q1.15 (0x8000 = 1.0).
REQ-011 SHALL have ports:
- out_valid  out  1  result valid;
- out_ready  in  1  consumer accepts.
REQ-012 SHALL have ports:
- v_next  out  16  updated potential, signed Q8.8;
- spike  out  1  upward threshold crossing flag, qualified by out_valid.

Function
REQ-013 SHALL capture v, i_ext, m, h, n on any rising edge where in_valid and in_ready are both 1.
REQ-014 in_ready SHALL be 1 only in state IDLE.
REQ-015 FSM states, one multiply per state, each advancing unconditionally:
- IDLE -> M2 -> M3 -> M3H -> GNA -> INA -> N2 -> N4 -> GK -> IK -> IL -> SUM -> DONE.
REQ-016 Products SHALL be:
- M2 p=m*m>>15; M3 p=p*m>>15; M3H p=p*h>>15;
- GNA g=G_NA*p>>15; INA i_na=g*(v-E_NA)>>>8;
- N2 q=n*n>>15; N4 q=q*q>>15;
- GK g=G_K*q>>15; IK i_k=g*(v-E_K)>>>8;
- IL i_l=G_L*(v-E_L)>>>8.
REQ-017 Arithmetic rules:
- all shifts truncate toward minus infinity;
- differences are 17-bit signed;
- products and currents are 32-bit signed;
- no intermediate saturation.
REQ-018 SUM SHALL compute acc = i_ext - i_na - i_k - i_l (32-bit signed) and v_next = sat16(v + (acc >>> DT_SHIFT)), clamped to [-32768, 32767].
REQ-019 SUM SHALL set spike = 1 iff v < V_TH and the saturated v_next >= V_TH.
REQ-020 out_valid SHALL rise on the 12th rising edge after the accepting edge (fixed latency 12 cycles).
REQ-021 In DONE, out_valid, v_next and spike SHALL hold stable while out_ready = 0.
REQ-022 The edge with out_valid and out_ready both 1 SHALL return to IDLE with out_valid = 0; a new operand is accepted no earlier than the next edge.
REQ-023 Gate inputs above 0x8000 SHALL be processed by the same formulas without clamping.
REQ-024 in_valid while busy SHALL be ignored; input port changes after acceptance SHALL NOT affect the result.

Reset
REQ-025 rst_n = 0 SHALL immediately, regardless of clk, force:
- state = IDLE;
- out_valid = 0, spike = 0, v_next = 0;
- all internal registers = 0;
- in_ready = 1 while rst_n = 0 is not required (in_ready may be 0 during reset).
REQ-026 Reset asserted mid-computation SHALL abandon the operation; no out_valid SHALL appear for it after reset release.
REQ-027 After rst_n deassertion, in_ready SHALL be 1 on the first rising edge.

Verification
REQ-028 Leak equilibrium: m=h=n=0, i_ext=0, v=-13923 -> v_next=-13923, spike=0, out_valid 12 cycles after accept.
REQ-029 Current step: m=h=n=0, i_ext=8192, v=-13923 -> v_next=-13667, spike=0.
REQ-030 Spike: m=h=n=0, i_ext=16384, v=-256 -> i_l=4110, v_next=127, spike=1; with i_ext=8192 -> v_next=-129, spike=0.
REQ-031 Saturation: m=h=n=0, i_ext=32767, v=32767 -> v_next=32767.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0; in_valid pulses during busy are ignored.
REQ-033 Reset at cycle 6 of a computation -> out_valid stays 0; the next operand after release gives the correct result at latency 12.
